// File: rtl/spm_ctl_pkg.sv
// rtl/spm_ctl_pkg.sv - shared constants and saturation helper for the SPM output stage
package spm_ctl_pkg;
    localparam int W_DEF      = 32;
    localparam int QROTM_DEF  = 28;
    localparam int QSLOPE_DEF = 31;
    localparam int CH_X0      = 0;
    localparam int CH_Y0      = 1;
    localparam int CH_Z0      = 2;
    localparam int CH_U0      = 3;
    localparam int SATW       = 128;

    // Symmetric clamp to +/-(2^(w-1)-1); callers narrow the result with a size cast.
    function automatic logic signed [SATW-1:0] saturate(input logic signed [SATW-1:0] v,
                                                         input int w);
        logic signed [SATW-1:0] lim;
        lim = (SATW'(1) <<< (w - 1)) - SATW'(1);
        if (v > lim)
            return lim;
        else if (v < -lim)
            return -lim;
        else
            return v;
    endfunction
endpackage

// File: rtl/spm_slew_limiter.sv
// rtl/spm_slew_limiter.sv - one rate-limited channel: moves cur toward target by at most step per tick
module spm_slew_limiter
    import spm_ctl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                hold,
    input  logic signed [W-1:0] target,
    input  logic signed [W-1:0] step,
    output logic signed [W-1:0] cur,
    output logic                settled
);
    logic signed [W:0]   stp, up, dn, nxt;
    logic signed [W-1:0] nxt_w;

    // One extra bit so cur +/- step can never wrap before the clamp.
    always_comb begin
        stp = step[W-1] ? '0 : (W+1)'(step);
        up  = (W+1)'(cur) + stp;
        dn  = (W+1)'(cur) - stp;
        if ((W+1)'(target) > up)
            nxt = up;
        else if ((W+1)'(target) < dn)
            nxt = dn;
        else
            nxt = (W+1)'(target);
        nxt_w = hold ? cur : W'(saturate(SATW'(nxt), W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= '0;
            settled <= 1'b0;
        end else if (tick) begin
            cur     <= nxt_w;
            settled <= (nxt_w == target);
        end
    end
endmodule

// File: rtl/axis_spm_control_ng.sv
// rtl/axis_spm_control_ng.sv - SPM output stage: rotation, slope plane and slewed offsets into X/Y/Z/U streams
module axis_spm_control_ng
    import spm_ctl_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int NCH    = 6,
    parameter int QROTM  = QROTM_DEF,
    parameter int QSLOPE = QSLOPE_DEF,
    parameter int RDECI  = 5
) (
    input  logic                  a_clk,
    input  logic                  a_rst,
    input  logic signed [W-1:0]   S_AXIS_Xs_tdata,
    input  logic                  S_AXIS_Xs_tvalid,
    input  logic signed [W-1:0]   S_AXIS_Ys_tdata,
    input  logic                  S_AXIS_Ys_tvalid,
    input  logic signed [W-1:0]   S_AXIS_Zs_tdata,
    input  logic                  S_AXIS_Zs_tvalid,
    input  logic signed [W-1:0]   S_AXIS_Z_tdata,
    input  logic                  S_AXIS_Z_tvalid,
    input  logic signed [W-1:0]   S_AXIS_U_tdata,
    input  logic                  S_AXIS_U_tvalid,
    input  logic signed [31:0]    rotmxx,
    input  logic signed [31:0]    rotmxy,
    input  logic signed [31:0]    slope_x,
    input  logic signed [31:0]    slope_y,
    input  logic [NCH*W-1:0]      offset_target,
    input  logic [NCH*W-1:0]      offset_step,
    input  logic signed [W-1:0]   slope_step,
    input  logic                  hold,
    output logic signed [W-1:0]   M_AXIS1_tdata,
    output logic                  M_AXIS1_tvalid,
    output logic signed [W-1:0]   M_AXIS2_tdata,
    output logic                  M_AXIS2_tvalid,
    output logic signed [W-1:0]   M_AXIS3_tdata,
    output logic                  M_AXIS3_tvalid,
    output logic signed [W-1:0]   M_AXIS4_tdata,
    output logic                  M_AXIS4_tvalid,
    output logic [NCH*W-1:0]      offset_mon,
    output logic [((NCH > 4) ? (NCH - 4) * W : 1)-1:0] aux_out,
    output logic [NCH-1:0]        settled
);
    localparam int RW = W + 34;
    localparam int DW = RW + 33;

    logic tick;
    generate
        if (RDECI == 0) begin : g_tick_always
            assign tick = 1'b1;
        end else begin : g_tick_cnt
            logic [RDECI-1:0] cnt;
            always_ff @(posedge a_clk or posedge a_rst) begin
                if (a_rst) cnt <= '0;
                else       cnt <= cnt + RDECI'(1);
            end
            assign tick = (cnt == '0);
        end
    endgenerate

    logic signed [W-1:0] off_cur [NCH];
    logic signed [31:0]  slp_cur [2];
    logic [1:0]          slope_settled_unused;

    // Offset channels first, then slope x and slope y sharing slope_step.
    generate
        for (genvar i = 0; i < NCH + 2; i++) begin : g_slew
            if (i < NCH) begin : g_off
                spm_slew_limiter #(.W(W)) u_slew (
                    .clk(a_clk), .rst(a_rst), .tick(tick), .hold(hold),
                    .target(offset_target[i*W +: W]), .step(offset_step[i*W +: W]),
                    .cur(off_cur[i]), .settled(settled[i])
                );
                assign offset_mon[i*W +: W] = off_cur[i];
            end else begin : g_slope
                spm_slew_limiter #(.W(32)) u_slew (
                    .clk(a_clk), .rst(a_rst), .tick(tick), .hold(hold),
                    .target((i == NCH) ? slope_x : slope_y), .step(32'(slope_step)),
                    .cur(slp_cur[i-NCH]), .settled(slope_settled_unused[i-NCH])
                );
            end
        end
        if (NCH > 4) begin : g_aux
            assign aux_out = offset_mon[NCH*W-1:4*W];
        end else begin : g_noaux
            assign aux_out = '0;
        end
    endgenerate

    logic signed [W-1:0]  xs_r, ys_r, zs_r, zv_r, u_r, x0_1, y0_1, u1, u0_1;
    logic signed [31:0]   mxx_r, mxy_r, slx1, sly1, slx2, sly2;
    logic signed [RW-1:0] rrx1, rry1, rx2, ry2, rx3, ry3;
    logic signed [W+1:0]  zp1, zp2, zp3;
    logic signed [W:0]    up2, up3;
    logic signed [DW-1:0] dzx3, dzy3, zs_out;
    logic [3:0]           vld;
    logic                 tvalid_r;

    assign zs_out = DW'(zp3) + (dzx3 >>> QSLOPE) + (dzy3 >>> QSLOPE);

    // Stage k consumes stage k-1 registers; offsets/slope ride along from the capture tick.
    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            xs_r <= '0; ys_r <= '0; zs_r <= '0; zv_r <= '0; u_r <= '0;
            mxx_r <= '0; mxy_r <= '0;
            rrx1 <= '0; rry1 <= '0; zp1 <= '0; x0_1 <= '0; y0_1 <= '0;
            u1 <= '0; u0_1 <= '0; slx1 <= '0; sly1 <= '0;
            rx2 <= '0; ry2 <= '0; up2 <= '0; zp2 <= '0; slx2 <= '0; sly2 <= '0;
            dzx3 <= '0; dzy3 <= '0; zp3 <= '0; rx3 <= '0; ry3 <= '0; up3 <= '0;
            M_AXIS1_tdata <= '0; M_AXIS2_tdata <= '0;
            M_AXIS3_tdata <= '0; M_AXIS4_tdata <= '0;
            vld <= '0; tvalid_r <= 1'b0;
        end else begin
            tvalid_r <= tick & vld[3];
            if (tick) begin
                vld <= {vld[2:0], 1'b1};
                if (S_AXIS_Xs_tvalid) xs_r <= S_AXIS_Xs_tdata;
                if (S_AXIS_Ys_tvalid) ys_r <= S_AXIS_Ys_tdata;
                if (S_AXIS_Zs_tvalid) zs_r <= S_AXIS_Zs_tdata;
                if (S_AXIS_Z_tvalid)  zv_r <= S_AXIS_Z_tdata;
                if (S_AXIS_U_tvalid)  u_r  <= S_AXIS_U_tdata;
                mxx_r <= rotmxx;
                mxy_r <= rotmxy;

                rrx1 <= RW'(mxx_r) * RW'(xs_r) + RW'(mxy_r) * RW'(ys_r);
                rry1 <= RW'(mxx_r) * RW'(ys_r) - RW'(mxy_r) * RW'(xs_r);
                zp1  <= (W+2)'(zs_r) + (W+2)'(zv_r) + (W+2)'(off_cur[CH_Z0]);
                x0_1 <= off_cur[CH_X0];
                y0_1 <= off_cur[CH_Y0];
                u1   <= u_r;
                u0_1 <= off_cur[CH_U0];
                slx1 <= slp_cur[0];
                sly1 <= slp_cur[1];

                rx2  <= (rrx1 >>> QROTM) + RW'(x0_1);
                ry2  <= (rry1 >>> QROTM) + RW'(y0_1);
                up2  <= (W+1)'(u1) + (W+1)'(u0_1);
                zp2  <= zp1;
                slx2 <= slx1;
                sly2 <= sly1;

                dzx3 <= DW'(slx2) * DW'(rx2);
                dzy3 <= DW'(sly2) * DW'(ry2);
                zp3  <= zp2;
                rx3  <= rx2;
                ry3  <= ry2;
                up3  <= up2;

                M_AXIS1_tdata <= W'(saturate(SATW'(rx3), W));
                M_AXIS2_tdata <= W'(saturate(SATW'(ry3), W));
                M_AXIS3_tdata <= W'(saturate(SATW'(zs_out), W));
                M_AXIS4_tdata <= W'(saturate(SATW'(up3), W));
            end
        end
    end

    assign M_AXIS1_tvalid = tvalid_r;
    assign M_AXIS2_tvalid = tvalid_r;
    assign M_AXIS3_tvalid = tvalid_r;
    assign M_AXIS4_tvalid = tvalid_r;
endmodule

// File: tb/tb_axis_spm_control_ng.sv
// tb/tb_axis_spm_control_ng.sv - directed self-checking bench for axis_spm_control_ng
module tb_axis_spm_control_ng;
    localparam int W = 32;
    localparam int NCH = 6;

    logic a_clk = 1'b0;
    logic rst = 1'b1, rst2 = 1'b1;
    always #5 a_clk = ~a_clk;

    logic signed [W-1:0] xs = 0, ys = 0, zs = 0, zv = 0, u = 0;
    logic xs_v = 1'b1, ys_v = 1'b1, zs_v = 1'b1, zv_v = 1'b1, u_v = 1'b1;
    logic signed [31:0] rotmxx = 0, rotmxy = 0, slope_x = 0, slope_y = 0;
    logic [NCH*W-1:0] off_tgt = '0, off_step = '0;
    logic signed [W-1:0] slope_step = 0;
    logic hold = 1'b0;

    logic signed [W-1:0] m1, m2, m3, m4, n1, n2, n3, n4;
    logic v1, v2, v3, v4, w1, w2, w3, w4;
    logic [NCH*W-1:0] mon0, mon2;
    logic [(NCH-4)*W-1:0] aux0, aux2;
    logic [NCH-1:0] set0, set2;

    axis_spm_control_ng #(.W(W), .NCH(NCH), .RDECI(0)) dut0 (
        .a_clk(a_clk), .a_rst(rst),
        .S_AXIS_Xs_tdata(xs), .S_AXIS_Xs_tvalid(xs_v),
        .S_AXIS_Ys_tdata(ys), .S_AXIS_Ys_tvalid(ys_v),
        .S_AXIS_Zs_tdata(zs), .S_AXIS_Zs_tvalid(zs_v),
        .S_AXIS_Z_tdata(zv), .S_AXIS_Z_tvalid(zv_v),
        .S_AXIS_U_tdata(u), .S_AXIS_U_tvalid(u_v),
        .rotmxx(rotmxx), .rotmxy(rotmxy), .slope_x(slope_x), .slope_y(slope_y),
        .offset_target(off_tgt), .offset_step(off_step), .slope_step(slope_step), .hold(hold),
        .M_AXIS1_tdata(m1), .M_AXIS1_tvalid(v1), .M_AXIS2_tdata(m2), .M_AXIS2_tvalid(v2),
        .M_AXIS3_tdata(m3), .M_AXIS3_tvalid(v3), .M_AXIS4_tdata(m4), .M_AXIS4_tvalid(v4),
        .offset_mon(mon0), .aux_out(aux0), .settled(set0)
    );

    axis_spm_control_ng #(.W(W), .NCH(NCH), .RDECI(2)) dut2 (
        .a_clk(a_clk), .a_rst(rst2),
        .S_AXIS_Xs_tdata(xs), .S_AXIS_Xs_tvalid(xs_v),
        .S_AXIS_Ys_tdata(ys), .S_AXIS_Ys_tvalid(ys_v),
        .S_AXIS_Zs_tdata(zs), .S_AXIS_Zs_tvalid(zs_v),
        .S_AXIS_Z_tdata(zv), .S_AXIS_Z_tvalid(zv_v),
        .S_AXIS_U_tdata(u), .S_AXIS_U_tvalid(u_v),
        .rotmxx(rotmxx), .rotmxy(rotmxy), .slope_x(slope_x), .slope_y(slope_y),
        .offset_target(off_tgt), .offset_step(off_step), .slope_step(slope_step), .hold(hold),
        .M_AXIS1_tdata(n1), .M_AXIS1_tvalid(w1), .M_AXIS2_tdata(n2), .M_AXIS2_tvalid(w2),
        .M_AXIS3_tdata(n3), .M_AXIS3_tvalid(w3), .M_AXIS4_tdata(n4), .M_AXIS4_tvalid(w4),
        .offset_mon(mon2), .aux_out(aux2), .settled(set2)
    );

    int passed = 0;
    int total = 0;
    int pulses;
    int exp_off[4] = '{30, 60, 90, 100};

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        total = total + 1;
        assert (got === exp) passed = passed + 1;
        else $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge a_clk);
    endtask

    initial begin
        cyc(3);
        chk("rst_m1", m1, 0);
        chk("rst_v1", v1, 0);
        chk("rst_m3", m3, 0);
        chk("rst_settled", set0, 0);
        chk("rst_mon", mon0, 0);
        chk("rst_aux", aux0, 0);
        chk("rst2_v1", w1, 0);

        rotmxx = 1 << 28; xs = 1000;
        rst = 1'b0; rst2 = 1'b0;
        cyc(4);
        chk("t1_no_valid_early", v1, 0);
        cyc(1);
        chk("t1_v1", v1, 1);
        chk("t1_v4", v4, 1);
        chk("t1_x", m1, 1000);
        chk("t1_y", m2, 0);
        chk("t1_z", m3, 0);
        chk("t1_u", m4, 0);

        rotmxx = 0; rotmxy = 1 << 28;
        cyc(5);
        chk("t2_x", m1, 0);
        chk("t2_y", m2, -1000);

        rotmxx = 1 << 28; rotmxy = 0; xs = 0;
        off_tgt[31:0] = 100; off_step[31:0] = 30;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("t3_slew", $signed(mon0[31:0]), exp_off[k]);
            chk("t3_settled", set0[0], (k == 3) ? 1 : 0);
        end
        hold = 1'b1; off_tgt[31:0] = 0;
        cyc(3);
        chk("t3_hold_cur", $signed(mon0[31:0]), 100);
        chk("t3_hold_settled", set0[0], 0);
        hold = 1'b0; off_step[31:0] = 32'h7FFF_FFFF;
        cyc(1);
        chk("t3_bigstep", $signed(mon0[31:0]), 0);
        chk("t3_bigstep_settled", set0[0], 1);
        off_tgt[31:0] = 50; off_step[31:0] = -5;
        cyc(2);
        chk("t3_negstep_cur", $signed(mon0[31:0]), 0);
        chk("t3_negstep_settled", set0[0], 0);

        off_step[31:0] = 32'h7FFF_FFFF; off_tgt[31:0] = 32'h100; xs = 32'h7FFF_FFF0;
        cyc(5);
        chk("t4_sat_pos", m1, 2147483647);
        chk("t4_y", m2, 0);
        off_tgt[31:0] = -256; xs = 32'h8000_0000;
        cyc(5);
        chk("t4_sat_neg", m1, -2147483647);

        off_tgt[31:0] = 0; xs = 2000; slope_x = 1 << 30; slope_step = 1 << 29;
        cyc(5);
        chk("t5_slope_half", m3, 500);
        cyc(1);
        chk("t5_slope_full", m3, 1000);
        chk("t5_x", m1, 2000);
        zs = 5; zv = 7;
        cyc(5);
        chk("t5_zsum", m3, 1012);
        zs = 999; zs_v = 1'b0;
        cyc(5);
        chk("t5_zs_held", m3, 1012);
        u = -50; off_tgt[3*32 +: 32] = 20; off_step[3*32 +: 32] = 32'h7FFF_FFFF;
        cyc(5);
        chk("t5_u", m4, -30);

        slope_x = 0; xs = 1234; ys = -77; zs = 0; zs_v = 1'b1; zv = 0; u = 9;
        off_tgt[3*32 +: 32] = 0;
        cyc(30);
        chk("t6_pre_x", n1, 1234);
        rst2 = 1'b1;
        #1;
        chk("t6_rst_x", n1, 0);
        chk("t6_rst_v", w1, 0);
        chk("t6_rst_mon", mon2, 0);
        chk("t6_rst_settled", set2, 0);
        @(negedge a_clk);
        rst2 = 1'b0;
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(1);
            pulses = pulses + int'(w1) + int'(w3);
        end
        chk("t6_no_valid_4ticks", pulses, 0);
        cyc(1);
        chk("t6_first_valid", w1, 1);
        chk("t6_valid_u", w4, 1);
        chk("t6_x", n1, 1234);
        chk("t6_y", n2, -77);
        chk("t6_u", n4, 9);
        cyc(1);
        chk("t6_valid_pulse", w1, 0);
        chk("t6_x_hold", n1, 1234);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
